// File: rtl/cpu_run_pkg.sv
// Shared encodings for the CPU run controller: modes, stop reasons, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_run_pkg;

    localparam logic [1:0] MODE_FREE   = 2'd0;
    localparam logic [1:0] MODE_BUDGET = 2'd1;
    localparam logic [1:0] MODE_STEP   = 2'd2;

    localparam logic [2:0] STOP_NONE   = 3'd0;
    localparam logic [2:0] STOP_HALT   = 3'd1;
    localparam logic [2:0] STOP_BUDGET = 3'd2;
    localparam logic [2:0] STOP_STUCK  = 3'd3;
    localparam logic [2:0] STOP_ABORT  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESET_CPU = 2'd1,
        ST_RUN       = 2'd2,
        ST_DONE      = 2'd3
    } run_state_t;

endpackage

// File: rtl/pc_stuck_detector.sv
// Flags a CPU whose PC has held one value for STUCK_LIMIT consecutive enabled cycles.
// Latency: stuck is combinational on the enabled cycle that completes the run of equal PCs.
// Backpressure: none; only cycles with en=1 are observed, others leave the state untouched.
module pc_stuck_detector #(
    parameter int STUCK_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] pc,
    output logic        stuck
);
    localparam int CNT_W = (STUCK_LIMIT < 2) ? 1 : $clog2(STUCK_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STUCK_LIMIT);

    logic [31:0]      last_pc;
    logic             last_vld;
    logic [CNT_W-1:0] streak;
    logic [CNT_W-1:0] streak_nxt;

    // Run length of identical PCs, counting the first cycle of the run; saturates at the limit
    always_comb begin
        streak_nxt = CNT_W'(1);
        if (last_vld && (pc == last_pc)) begin
            streak_nxt = (streak >= LIMIT) ? LIMIT : streak + CNT_W'(1);
        end
        stuck = (STUCK_LIMIT != 0) && en && (streak_nxt >= LIMIT);
    end

    // Remember the PC seen on the last enabled cycle; cleared at each run launch
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
            streak   <= '0;
        end else if (en) begin
            last_pc  <= pc;
            last_vld <= 1'b1;
            streak   <= streak_nxt;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Sequences a CPU: holds reset, releases it, gates cpu_en in free/budget/single-step modes, stops on halt/budget/stuck/abort.
// Latency: all outputs registered; a stop condition seen on an enabled cycle drops cpu_en on the following cycle.
// Backpressure: none; start is ignored while running, abort is ignored when idle or done.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int CYCLE_W        = 32,
    parameter int DEFAULT_BUDGET = 68,
    parameter int RST_CYCLES     = 2,
    parameter int STUCK_LIMIT    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               start,
    input  logic [CYCLE_W-1:0] budget,
    input  logic               step,
    input  logic               abort,
    input  logic               halt_in,
    input  logic [31:0]        pc_in,
    output logic               cpu_rst,
    output logic               cpu_en,
    output logic               running,
    output logic               done,
    output logic [2:0]         stop_reason,
    output logic [CYCLE_W-1:0] cycle_count
);
    localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
    localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

    run_state_t         state, state_nxt;
    logic [1:0]         mode_q, mode_nxt;
    logic [CYCLE_W-1:0] budget_q, budget_nxt;
    logic [RC_W-1:0]    rst_cnt, rst_cnt_nxt;
    logic               cpu_rst_nxt, cpu_en_nxt, running_nxt, done_nxt;
    logic [2:0]         stop_nxt;
    logic [CYCLE_W-1:0] count_nxt, count_inc;
    logic               det_clr, stuck;

    pc_stuck_detector #(.STUCK_LIMIT(STUCK_LIMIT)) u_stuck (
        .clk   (clk),
        .rst   (rst),
        .clr   (det_clr),
        .en    (cpu_en),
        .pc    (pc_in),
        .stuck (stuck)
    );

    // Next-state and next-output logic; every register holds unless a branch below changes it
    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_q;
        budget_nxt  = budget_q;
        rst_cnt_nxt = rst_cnt;
        cpu_rst_nxt = cpu_rst;
        cpu_en_nxt  = cpu_en;
        running_nxt = running;
        done_nxt    = done;
        stop_nxt    = stop_reason;
        count_nxt   = cycle_count;
        det_clr     = 1'b0;
        count_inc   = (&cycle_count) ? cycle_count : cycle_count + CYCLE_W'(1);

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt   = ST_RESET_CPU;
                    mode_nxt    = mode;
                    budget_nxt  = (budget == '0) ? CYCLE_W'(DEFAULT_BUDGET) : budget;
                    rst_cnt_nxt = '0;
                    cpu_rst_nxt = 1'b1;
                    cpu_en_nxt  = 1'b0;
                    running_nxt = 1'b1;
                    done_nxt    = 1'b0;
                    stop_nxt    = STOP_NONE;
                    count_nxt   = '0;
                    det_clr     = 1'b1;
                end
            end
            ST_RESET_CPU: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt   = ST_RUN;
                    cpu_rst_nxt = 1'b0;
                    // single-step waits for its first step pulse
                    cpu_en_nxt  = (mode_q != MODE_STEP);
                end else begin
                    rst_cnt_nxt = rst_cnt + RC_W'(1);
                end
            end
            ST_RUN: begin
                if (cpu_en) begin
                    count_nxt = count_inc;
                end
                cpu_en_nxt = (mode_q == MODE_STEP) ? step : 1'b1;
                if (cpu_en && halt_in) begin
                    state_nxt = ST_DONE;
                    stop_nxt  = STOP_HALT;
                end else if (cpu_en && (mode_q == MODE_BUDGET) && (count_inc == budget_q)) begin
                    state_nxt = ST_DONE;
                    stop_nxt  = STOP_BUDGET;
                end else if (stuck) begin
                    state_nxt = ST_DONE;
                    stop_nxt  = STOP_STUCK;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // abort wins over every other stop cause, including during CPU reset
        if (abort && ((state == ST_RESET_CPU) || (state == ST_RUN))) begin
            state_nxt = ST_DONE;
            stop_nxt  = STOP_ABORT;
        end

        // entering DONE: freeze the CPU out of reset so its state can be inspected
        if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
            cpu_rst_nxt = 1'b0;
            cpu_en_nxt  = 1'b0;
            running_nxt = 1'b0;
            done_nxt    = 1'b1;
        end
    end

    // State and output registers; synchronous reset has priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_q      <= 2'd0;
            budget_q    <= '0;
            rst_cnt     <= '0;
            cpu_rst     <= 1'b1;
            cpu_en      <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            stop_reason <= STOP_NONE;
            cycle_count <= '0;
        end else begin
            state       <= state_nxt;
            mode_q      <= mode_nxt;
            budget_q    <= budget_nxt;
            rst_cnt     <= rst_cnt_nxt;
            cpu_rst     <= cpu_rst_nxt;
            cpu_en      <= cpu_en_nxt;
            running     <= running_nxt;
            done        <= done_nxt;
            stop_reason <= stop_nxt;
            cycle_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with immediate-assertion checks at each step.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; every wait on the DUT is bounded by a cycle budget.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        start;
    logic [31:0] budget;
    logic        step;
    logic        abort;
    logic        halt_in;
    logic [31:0] pc_in;
    logic        cpu_rst;
    logic        cpu_en;
    logic        running;
    logic        done;
    logic [2:0]  stop_reason;
    logic [31:0] cycle_count;

    int errors = 0;
    int checks = 0;
    bit pc_inc = 1'b1;

    cpu_run_ctrl #(
        .CYCLE_W(32), .DEFAULT_BUDGET(68), .RST_CYCLES(2), .STUCK_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .budget(budget),
        .step(step), .abort(abort), .halt_in(halt_in), .pc_in(pc_in),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .running(running), .done(done),
        .stop_reason(stop_reason), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (pc_inc) pc_in = pc_in + 32'd4;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start and advance to the first RUN cycle (start edge + RST_CYCLES edges)
    task automatic launch(input logic [1:0] m, input logic [31:0] b);
        mode = m; budget = b; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    // Count enabled cycles until cpu_en drops; raise halt_in during enabled cycle halt_at
    task automatic run_until_stop(input int halt_at, output int n);
        n = 0;
        while (cpu_en && n < 300) begin
            n++;
            halt_in = (n == halt_at);
            tick();
        end
        halt_in = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; mode = 2'd0; start = 1'b0; budget = 32'd0; step = 1'b0;
        abort = 1'b0; halt_in = 1'b0; pc_in = 32'h100;
        tick();
        tick();
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_reason", 32'(stop_reason), 32'd0);
        chk("rst_count", cycle_count, 32'd0);
        rst = 1'b0;

        // abort while idle has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_done", 32'(done), 32'd0);
        chk("idle_abort_rst", 32'(cpu_rst), 32'd1);

        // budget mode, 68 cycles, with reset-release timing
        mode = 2'd1; budget = 32'd68; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b68_rst_c1", 32'(cpu_rst), 32'd1);
        chk("b68_run_c1", 32'(running), 32'd1);
        chk("b68_en_c1", 32'(cpu_en), 32'd0);
        tick();
        chk("b68_rst_c2", 32'(cpu_rst), 32'd1);
        chk("b68_en_c2", 32'(cpu_en), 32'd0);
        tick();
        chk("b68_rst_fall", 32'(cpu_rst), 32'd0);
        chk("b68_en_rise", 32'(cpu_en), 32'd1);
        run_until_stop(0, n);
        chk("b68_en_cycles", 32'(n), 32'd68);
        chk("b68_done", 32'(done), 32'd1);
        chk("b68_running", 32'(running), 32'd0);
        chk("b68_reason", 32'(stop_reason), 32'd2);
        chk("b68_count", cycle_count, 32'd68);
        chk("b68_cpu_rst", 32'(cpu_rst), 32'd0);
        tick(); tick(); tick();
        chk("b68_hold_count", cycle_count, 32'd68);
        chk("b68_hold_done", 32'(done), 32'd1);

        // free-run, halt on 10th enabled cycle
        launch(2'd0, 32'd0);
        chk("halt_start_reason", 32'(stop_reason), 32'd0);
        run_until_stop(10, n);
        chk("halt_en_cycles", 32'(n), 32'd10);
        chk("halt_count", cycle_count, 32'd10);
        chk("halt_reason", 32'(stop_reason), 32'd1);
        chk("halt_en_low", 32'(cpu_en), 32'd0);

        // single-step: three isolated pulses spaced five cycles
        launch(2'd2, 32'd0);
        chk("step_idle_en", 32'(cpu_en), 32'd0);
        chk("step_cpu_rst", 32'(cpu_rst), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            chk("step_pulse_hi", 32'(cpu_en), 32'd1);
            tick();
            chk("step_pulse_lo", 32'(cpu_en), 32'd0);
            tick(); tick(); tick();
        end
        chk("step_count", cycle_count, 32'd3);
        chk("step_done", 32'(done), 32'd0);
        chk("step_running", 32'(running), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("step_abort_reason", 32'(stop_reason), 32'd4);
        chk("step_abort_count", cycle_count, 32'd3);

        // free-run with constant PC: stuck after 8 enabled cycles
        pc_inc = 1'b0; pc_in = 32'h0000_0040;
        launch(2'd0, 32'd0);
        run_until_stop(0, n);
        chk("stuck_en_cycles", 32'(n), 32'd8);
        chk("stuck_reason", 32'(stop_reason), 32'd3);
        chk("stuck_count", cycle_count, 32'd8);

        // halt and stuck coincide: halt wins
        launch(2'd0, 32'd0);
        run_until_stop(8, n);
        chk("halt_stuck_reason", 32'(stop_reason), 32'd1);
        chk("halt_stuck_count", cycle_count, 32'd8);
        pc_inc = 1'b1;

        // budget 0 falls back to the default of 68
        launch(2'd1, 32'd0);
        run_until_stop(0, n);
        chk("bdef_en_cycles", 32'(n), 32'd68);
        chk("bdef_reason", 32'(stop_reason), 32'd2);

        // budget 5 with halt on cycle 5: halt wins
        launch(2'd1, 32'd5);
        run_until_stop(5, n);
        chk("b5_halt_reason", 32'(stop_reason), 32'd1);
        chk("b5_halt_count", cycle_count, 32'd5);

        // abort mid-run during the 5th enabled cycle
        launch(2'd0, 32'd0);
        tick(); tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_reason", 32'(stop_reason), 32'd4);
        chk("abort_count", cycle_count, 32'd5);
        chk("abort_en", 32'(cpu_en), 32'd0);
        chk("abort_done", 32'(done), 32'd1);

        // relaunch clears the count; start while running is ignored
        mode = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("relaunch_count", cycle_count, 32'd0);
        chk("relaunch_reason", 32'(stop_reason), 32'd0);
        chk("relaunch_done", 32'(done), 32'd0);
        tick(); tick();
        tick(); tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_count", cycle_count, 32'd4);
        chk("start_ignored_run", 32'(running), 32'd1);

        // synchronous reset mid-run
        rst = 1'b1;
        tick();
        chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("mid_rst_running", 32'(running), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_reason", 32'(stop_reason), 32'd0);
        chk("mid_rst_count", cycle_count, 32'd0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
